jsv_hex_display_ctrl: RTL and testbench



---
 rtl/jsv_hex_display_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_jsv_hex_display_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jsv_hex_display_ctrl.sv
// jsv_hex_display_ctrl
// Avalon-MM slave driving a time-multiplexed bank of seven-segment hex digits
// for the Julia set visualizer status readout.
//
// Registers (address):
//   0 DATA  [4N-1:0]  nibble i drives digit i
//   1 CTRL  bit0 SCAN_EN, bits[8+N-1:8] BLANK mask
//   2 DP    [N-1:0]   decimal points
//   3 BLINK [N-1:0]   only with JSV_HEX_DISPLAY_BLINK_EN defined, else reads 0
//
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   address, chipselect, write_n,
//   writedata, readdata               Avalon-MM slave (combinational read)
//   out_port                          raw DATA register (unshadowed)
//   seg[6:0] (bit0 = a), dp           segment drive of the active digit
//   digit_sel[N-1:0]                  one-hot digit enable
//
// Optional feature macro: JSV_HEX_DISPLAY_BLINK_EN (blink register plus an
// 8-bit frame counter; blink phase = frame_cnt[7]).
module jsv_hex_display_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [4*NUM_DIGITS-1:0] out_port,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                  wr_en;
    logic [DATA_W-1:0]     data_reg;
    logic [NUM_DIGITS-1:0] dp_reg;
    logic [NUM_DIGITS-1:0] blank_reg;
    logic                  scan_en;
    logic [CNT_W-1:0]      pre_cnt;
    logic [IDX_W-1:0]      dig_idx;
    logic                  tick;
    logic                  frame_end;
    logic [DATA_W-1:0]     shd_data;
    logic [NUM_DIGITS-1:0] shd_dp;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [NUM_DIGITS-1:0] blink_rd;
    logic [NUM_DIGITS-1:0] dark_mask;
    logic [3:0]            active_nib;
    logic                  active_dark;
    logic [6:0]            seg_p1;
    logic                  dp_p1;
    logic [NUM_DIGITS-1:0] digit_sel_p1;
    logic                  unused_wdata;

    // Active-high glyph table, bit0 = segment a.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] seg_level(input logic [6:0] on);
        return SEG_ACTIVE_LOW ? ~on : on;
    endfunction

    function automatic logic dp_level(input logic on);
        return SEG_ACTIVE_LOW ? ~on : on;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] dig_level(input logic [NUM_DIGITS-1:0] on);
        return DIG_ACTIVE_LOW ? ~on : on;
    endfunction

    assign wr_en        = chipselect & ~write_n;
    assign out_port     = data_reg;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg  <= '0;
            dp_reg    <= '0;
            blank_reg <= '0;
            scan_en   <= 1'b1;
        end else if (wr_en) begin
            case (address)
                2'd0: data_reg <= writedata[DATA_W-1:0];
                2'd1: begin
                    scan_en   <= writedata[0];
                    blank_reg <= writedata[8 +: NUM_DIGITS];
                end
                2'd2: dp_reg <= writedata[NUM_DIGITS-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[DATA_W-1:0] = data_reg;
            2'd1: begin
                readdata[0]               = scan_en;
                readdata[8 +: NUM_DIGITS] = blank_reg;
            end
            2'd2: readdata[NUM_DIGITS-1:0] = dp_reg;
            default: readdata[NUM_DIGITS-1:0] = blink_rd;
        endcase
    end

    // A tick that clears SCAN_EN in the same cycle still completes, because
    // the registered scan_en is what qualifies it.
    assign tick      = scan_en && (pre_cnt == CNT_LAST);
    assign frame_end = tick && (dig_idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            dig_idx <= '0;
        end else if (scan_en) begin
            if (tick) begin
                pre_cnt <= '0;
                dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
            end else begin
                pre_cnt <= pre_cnt + CNT_W'(1);
            end
        end
    end

    // Shadows capture the pre-write register contents on the boundary edge,
    // so a coincident DATA write shows up one frame later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shd_data <= '0;
            shd_dp   <= '0;
        end else if (!scan_en || frame_end) begin
            shd_data <= data_reg;
            shd_dp   <= dp_reg;
        end
    end

`ifdef JSV_HEX_DISPLAY_BLINK_EN
    logic [NUM_DIGITS-1:0] blink_reg;
    logic [7:0]            frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_reg <= '0;
            frame_cnt <= '0;
        end else begin
            if (wr_en && address == 2'd3)
                blink_reg <= writedata[NUM_DIGITS-1:0];
            if (frame_end)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign blink_mask = frame_cnt[7] ? blink_reg : '0;
    assign blink_rd   = blink_reg;
`else
    assign blink_mask = '0;
    assign blink_rd   = '0;
`endif

    assign dark_mask   = blank_reg | blink_mask;
    assign active_nib  = shd_data[4*dig_idx +: 4];
    assign active_dark = dark_mask[dig_idx];

    // Output stage p1: registered drive of the digit selected by dig_idx.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_p1       <= seg_level(7'h00);
            dp_p1        <= dp_level(1'b0);
            digit_sel_p1 <= dig_level('0);
        end else begin
            seg_p1       <= active_dark ? seg_level(7'h00) : seg_level(hex7(active_nib));
            dp_p1        <= dp_level(!active_dark && shd_dp[dig_idx]);
            digit_sel_p1 <= dig_level(scan_en ? (NUM_DIGITS'(1) << dig_idx) : '0);
        end
    end

    assign seg       = seg_p1;
    assign dp        = dp_p1;
    assign digit_sel = digit_sel_p1;

endmodule

// File: tb/tb_jsv_hex_display_ctrl.sv
// Testbench for jsv_hex_display_ctrl (NUM_DIGITS=4, SCAN_DIV=4, segments
// active-low, digit selects active-high). The reference model tracks the
// number of enabled scan cycles and derives the digit index and frame
// boundaries arithmetically from that count.
module tb_jsv_hex_display_ctrl;

    localparam int N     = 4;
    localparam int SD    = 4;
    localparam int FRAME = N * SD;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [15:0] out_port;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  digit_sel;

    int tests_run = 0;
    int tests_failed = 0;

    jsv_hex_display_ctrl #(
        .NUM_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .seg(seg), .dp(dp), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_data, m_shd_data;
    logic [3:0]  m_dp, m_shd_dp, m_blank, m_blink;
    logic        m_en;
    int          en_cycles, frames;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_sel;

    // Glyphs built from the lit segment letters of each hex character.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        string s;
        logic [6:0] g;
        g = 7'h00;
        case (v)
            4'h0: s = "abcdef";   4'h1: s = "bc";      4'h2: s = "abdeg";  4'h3: s = "abcdg";
            4'h4: s = "bcfg";     4'h5: s = "acdfg";   4'h6: s = "acdefg"; 4'h7: s = "abc";
            4'h8: s = "abcdefg";  4'h9: s = "abcdfg";  4'hA: s = "abcefg"; 4'hB: s = "cdefg";
            4'hC: s = "adef";     4'hD: s = "bcdeg";   4'hE: s = "adefg";  default: s = "aefg";
        endcase
        for (int i = 0; i < s.len(); i++) g[int'(s[i]) - 97] = 1'b1;
        return g;
    endfunction

    function int cur_idx();
        return (en_cycles / SD) % N;
    endfunction

    function logic is_dark(input int i);
        return m_blank[i] | (((frames % 256) >= 128) & m_blink[i]);
    endfunction

    function logic [31:0] exp_read(input int a);
        case (a)
            0: return {16'd0, m_data};
            1: return {16'd0, 4'd0, m_blank, 7'd0, m_en};
            2: return {28'd0, m_dp};
            default: return {28'd0, m_blink};
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data <= '0; m_shd_data <= '0; m_dp <= '0; m_shd_dp <= '0;
            m_blank <= '0; m_blink <= '0; m_en <= 1'b1;
            en_cycles <= 0; frames <= 0;
            e_seg <= 7'h7F; e_dp <= 1'b1; e_sel <= 4'b0000;
        end else begin
            e_sel <= m_en ? (4'b0001 << cur_idx()) : 4'b0000;
            e_seg <= is_dark(cur_idx()) ? 7'h7F : ~glyph(m_shd_data[4*cur_idx() +: 4]);
            e_dp  <= is_dark(cur_idx()) ? 1'b1 : ~m_shd_dp[cur_idx()];
            if (m_en) en_cycles <= en_cycles + 1;
            if (!m_en) begin
                m_shd_data <= m_data; m_shd_dp <= m_dp;
            end else if ((en_cycles + 1) % FRAME == 0) begin
                m_shd_data <= m_data; m_shd_dp <= m_dp; frames <= frames + 1;
            end
            if (chipselect && !write_n) begin
                case (address)
                    2'd0: m_data <= writedata[15:0];
                    2'd1: begin m_en <= writedata[0]; m_blank <= writedata[11:8]; end
                    2'd2: m_dp <= writedata[3:0];
`ifdef JSV_HEX_DISPLAY_BLINK_EN
                    default: m_blink <= writedata[3:0];
`else
                    default: ;
`endif
                endcase
            end
        end
    end

    // Call right after a negedge; returns at the following negedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        tests_run++;
        if ({seg, dp, digit_sel, out_port} !== {7'h7F, 1'b1, 4'b0000, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset_outputs seg=%h dp=%b sel=%b out=%h, need seg=7f dp=1 sel=0000 out=0000",
                     seg, dp, digit_sel, out_port);
        end
        for (int a = 0; a < 4; a++) begin
            address = 2'(a); #1;
            tests_run++;
            if (readdata !== ((a == 1) ? 32'd1 : 32'd0)) begin
                tests_failed++;
                $display("FAIL reset_read addr=%0d got=%h need=%h", a, readdata, (a == 1) ? 32'd1 : 32'd0);
            end
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (digit_sel !== 4'b0001 || seg !== 7'h40) begin
            tests_failed++;
            $display("FAIL first_edge sel=%b seg=%h, need sel=0001 seg=40", digit_sel, seg);
        end
        repeat (2 * FRAME + 2) begin
            @(negedge clk);
            tests_run++;
            if ({seg, dp, digit_sel, out_port} !== {e_seg, e_dp, e_sel, m_data}) begin
                tests_failed++;
                $display("FAIL reset_scan t=%0t got seg=%h dp=%b sel=%b out=%h need seg=%h dp=%b sel=%b out=%h",
                         $time, seg, dp, digit_sel, out_port, e_seg, e_dp, e_sel, m_data);
            end
        end
    endtask

    task automatic test_mid_write();
        int guard = 0;
        while (en_cycles % FRAME != 6 && guard < 4 * FRAME) begin @(negedge clk); guard++; end
        tests_run++;
        if (guard >= 4 * FRAME) begin tests_failed++; $display("FAIL mid_write_wait timeout"); end
        bus_write(2'd0, 32'h0000_1A2F);
        tests_run++;
        if (out_port !== 16'h1A2F) begin
            tests_failed++;
            $display("FAIL mid_write_out_port got=%h need=1a2f", out_port);
        end
        repeat (2 * FRAME + 3) begin
            @(negedge clk);
            tests_run++;
            if ({seg, dp, digit_sel, out_port} !== {e_seg, e_dp, e_sel, m_data}) begin
                tests_failed++;
                $display("FAIL mid_write_scan t=%0t got seg=%h dp=%b sel=%b out=%h need seg=%h dp=%b sel=%b out=%h",
                         $time, seg, dp, digit_sel, out_port, e_seg, e_dp, e_sel, m_data);
            end
        end
    endtask

    task automatic test_scan_enable();
        @(negedge clk);
        bus_write(2'd1, 32'h0);
        repeat (12) begin
            @(negedge clk);
            tests_run++;
            if ({seg, dp, digit_sel, out_port} !== {e_seg, e_dp, e_sel, m_data}) begin
                tests_failed++;
                $display("FAIL scan_off t=%0t got seg=%h dp=%b sel=%b need seg=%h dp=%b sel=%b",
                         $time, seg, dp, digit_sel, e_seg, e_dp, e_sel);
            end
        end
        bus_write(2'd1, 32'h1);
        repeat (FRAME + 5) begin
            @(negedge clk);
            tests_run++;
            if ({seg, dp, digit_sel, out_port} !== {e_seg, e_dp, e_sel, m_data}) begin
                tests_failed++;
                $display("FAIL scan_resume t=%0t got seg=%h dp=%b sel=%b need seg=%h dp=%b sel=%b",
                         $time, seg, dp, digit_sel, e_seg, e_dp, e_sel);
            end
        end
    endtask

    task automatic test_blank();
        @(negedge clk);
        bus_write(2'd1, 32'h0401);
        bus_write(2'd2, 32'h1);
        repeat (2 * FRAME + 2) begin
            @(negedge clk);
            tests_run++;
            if ({seg, dp, digit_sel} !== {e_seg, e_dp, e_sel}) begin
                tests_failed++;
                $display("FAIL blank t=%0t got seg=%h dp=%b sel=%b need seg=%h dp=%b sel=%b",
                         $time, seg, dp, digit_sel, e_seg, e_dp, e_sel);
            end
        end
        bus_write(2'd1, 32'h1);
        bus_write(2'd2, 32'h0);
    endtask

    task automatic test_wrap_write();
        for (int k = 0; k < 3; k++) begin
            int guard = 0;
            @(negedge clk);
            while (en_cycles % FRAME != FRAME - 1 && guard < 4 * FRAME) begin @(negedge clk); guard++; end
            tests_run++;
            if (guard >= 4 * FRAME) begin tests_failed++; $display("FAIL wrap_wait timeout"); end
            bus_write(2'd0, $urandom());
            repeat (2 * FRAME) begin
                @(negedge clk);
                tests_run++;
                if ({seg, dp, digit_sel, out_port} !== {e_seg, e_dp, e_sel, m_data}) begin
                    tests_failed++;
                    $display("FAIL wrap_write t=%0t got seg=%h sel=%b out=%h need seg=%h sel=%b out=%h",
                             $time, seg, digit_sel, out_port, e_seg, e_sel, m_data);
                end
            end
        end
    endtask

    task automatic test_random_regs();
        for (int it = 0; it < 40; it++) begin
            logic [1:0]  a;
            logic [31:0] d;
            a = 2'($urandom_range(0, 3));
            d = $urandom();
            if (a == 2'd1) d[0] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            bus_write(a, d);
            repeat ($urandom_range(1, 12)) begin
                @(negedge clk);
                tests_run++;
                if ({seg, dp, digit_sel, out_port} !== {e_seg, e_dp, e_sel, m_data}) begin
                    tests_failed++;
                    $display("FAIL random_scan t=%0t got seg=%h dp=%b sel=%b out=%h need seg=%h dp=%b sel=%b out=%h",
                             $time, seg, dp, digit_sel, out_port, e_seg, e_dp, e_sel, m_data);
                end
            end
            for (int r = 0; r < 4; r++) begin
                address = 2'(r); #1;
                tests_run++;
                if (readdata !== exp_read(r)) begin
                    tests_failed++;
                    $display("FAIL random_read addr=%0d got=%h need=%h", r, readdata, exp_read(r));
                end
            end
        end
        @(negedge clk);
        bus_write(2'd1, 32'h1);
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        @(negedge clk);
        bus_write(2'd0, 32'hBEEF);
        while (en_cycles % FRAME != 9 && guard < 4 * FRAME) begin @(negedge clk); guard++; end
        tests_run++;
        if (guard >= 4 * FRAME) begin tests_failed++; $display("FAIL reset_mid_wait timeout"); end
        #2 reset = 1'b1;
        #1;
        address = 2'd1;
        #1;
        tests_run++;
        if ({seg, dp, digit_sel, out_port, readdata} !== {7'h7F, 1'b1, 4'b0000, 16'h0000, 32'd1}) begin
            tests_failed++;
            $display("FAIL reset_mid seg=%h dp=%b sel=%b out=%h ctrl=%h, need 7f 1 0000 0000 00000001",
                     seg, dp, digit_sel, out_port, readdata);
        end
        @(negedge clk); reset = 1'b0;
        repeat (FRAME) begin
            @(negedge clk);
            tests_run++;
            if ({seg, dp, digit_sel, out_port} !== {e_seg, e_dp, e_sel, m_data}) begin
                tests_failed++;
                $display("FAIL reset_mid_scan t=%0t got seg=%h sel=%b need seg=%h sel=%b",
                         $time, seg, digit_sel, e_seg, e_sel);
            end
        end
    endtask

    task automatic test_blink();
`ifdef JSV_HEX_DISPLAY_BLINK_EN
        int guard = 0;
        @(negedge clk);
        bus_write(2'd0, 32'h1234);
        bus_write(2'd3, 32'h2);
        address = 2'd3; #1;
        tests_run++;
        if (readdata !== 32'h2) begin
            tests_failed++;
            $display("FAIL blink_read got=%h need=00000002", readdata);
        end
        while (frames < 260 && guard < 300 * FRAME) begin
            @(negedge clk);
            guard++;
            tests_run++;
            if ({seg, dp, digit_sel} !== {e_seg, e_dp, e_sel}) begin
                tests_failed++;
                $display("FAIL blink t=%0t frame=%0d got seg=%h sel=%b need seg=%h sel=%b",
                         $time, frames, seg, digit_sel, e_seg, e_sel);
            end
        end
        tests_run++;
        if (frames < 260) begin tests_failed++; $display("FAIL blink_wait frames=%0d need>=260", frames); end
`else
        @(negedge clk);
        bus_write(2'd3, 32'hFFFF_FFFF);
        address = 2'd3; #1;
        tests_run++;
        if (readdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL blink_absent_read got=%h need=00000000", readdata);
        end
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_mid_write();
        test_scan_enable();
        test_blank();
        test_wrap_write();
        test_random_regs();
        test_reset_mid();
        test_blink();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
